// File: rtl/pulse_stretch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pulse_stretch_pkg
// Description : Shared state encoding and default timing constants for
//               pulse_stretch and its counter.
// Revision    : 1.0 - initial release
// ============================================================================
package pulse_stretch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_HOLD = 2'b01,
        ST_GAP  = 2'b10
    } state_t;

    localparam int c_HOLD_DEFAULT  = 8;
    localparam int c_GAP_DEFAULT   = 2;
    localparam int c_CNT_W_DEFAULT = 8;

endpackage
`default_nettype wire

// File: rtl/load_down_counter.sv
`default_nettype none
// ============================================================================
// Module      : load_down_counter
// Description : Loadable down-counter with zero flag; stops at zero.
// Revision    : 1.0 - initial release
// ============================================================================
module load_down_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/pulse_stretch.sv
`default_nettype none
// ============================================================================
// Module      : pulse_stretch
// Description : Stretches a one-cycle pulse into a HOLD-cycle level followed
//               by a GAP-cycle low guard. Build macro RETRIGGER_EN lets a
//               pulse during HOLD reload the hold time instead of dropping it.
// Revision    : 1.0 - initial release
// ============================================================================
module pulse_stretch
    import pulse_stretch_pkg::*;
#(
    parameter int HOLD  = c_HOLD_DEFAULT,
    parameter int GAP   = c_GAP_DEFAULT,
    parameter int CNT_W = c_CNT_W_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic pulse,
    output logic level,
    output logic busy,
    output logic dropped
);

    localparam logic [CNT_W-1:0] c_HOLD_LD = CNT_W'(HOLD - 1);
    localparam logic [CNT_W-1:0] c_GAP_LD  = CNT_W'((GAP > 0) ? (GAP - 1) : 0);

    state_t           r_state;
    state_t           w_next;
    logic             r_dropped;
    logic             w_drop;
    logic             w_load;
    logic [CNT_W-1:0] w_load_val;
    logic             w_dec;
    logic             w_zero;

    load_down_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_dec      (w_dec),
        .o_zero     (w_zero)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_dropped <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_dropped <= w_drop;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_load     = 1'b0;
        w_load_val = c_HOLD_LD;
        w_dec      = 1'b0;
        w_drop     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (pulse) begin
                    w_next = ST_HOLD;
                    w_load = 1'b1;
                end
            end
            ST_HOLD: begin
`ifdef RETRIGGER_EN
                // A reload wins over expiry, even on the last hold cycle.
                if (pulse) begin
                    w_load = 1'b1;
                end else if (w_zero) begin
                    if (GAP > 0) begin
                        w_next     = ST_GAP;
                        w_load     = 1'b1;
                        w_load_val = c_GAP_LD;
                    end else begin
                        w_next = ST_IDLE;
                    end
                end else begin
                    w_dec = 1'b1;
                end
`else
                w_drop = pulse;
                if (w_zero) begin
                    if (GAP > 0) begin
                        w_next     = ST_GAP;
                        w_load     = 1'b1;
                        w_load_val = c_GAP_LD;
                    end else begin
                        w_next = ST_IDLE;
                    end
                end else begin
                    w_dec = 1'b1;
                end
`endif
            end
            ST_GAP: begin
                w_drop = pulse;
                if (w_zero) begin
                    w_next = ST_IDLE;
                end else begin
                    w_dec = 1'b1;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        level   = (r_state == ST_HOLD);
        busy    = (r_state != ST_IDLE);
        dropped = r_dropped;
    end

endmodule
`default_nettype wire

// File: tb/tb_pulse_stretch.sv
`default_nettype none
// ============================================================================
// Module      : tb_pulse_stretch
// Description : Directed self-checking bench for pulse_stretch, HOLD=4 GAP=2.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pulse_stretch;

    logic clk = 1'b0;
    logic rst;
    logic pulse;
    logic level;
    logic busy;
    logic dropped;

    int n_total = 0;
    int n_bad   = 0;

    pulse_stretch #(
        .HOLD  (4),
        .GAP   (2),
        .CNT_W (8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .pulse   (pulse),
        .level   (level),
        .busy    (busy),
        .dropped (dropped)
    );

    always #5 clk = ~clk;

    task automatic check_bit(input string tag, input logic got, input logic exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    // Bit n of each mask describes cycle n (the interval after edge n):
    // pm/rm are inputs driven during that cycle, lm/bm/dm the expected outputs.
    task automatic scen(input string nm, input logic [31:0] pm, input logic [31:0] rm,
                        input logic [31:0] lm, input logic [31:0] bm, input logic [31:0] dm);
        rst   = 1'b0;
        pulse = 1'b0;
        repeat (2) @(posedge clk);
        for (int n = 0; n < 32; n++) begin
            @(posedge clk);
            #1;
            pulse = pm[n];
            rst   = ~rm[n];
            @(negedge clk);
            check_bit($sformatf("%s level c%0d", nm, n), level, lm[n]);
            check_bit($sformatf("%s busy c%0d", nm, n), busy, bm[n]);
            check_bit($sformatf("%s dropped c%0d", nm, n), dropped, dm[n]);
        end
        #1;
        pulse = 1'b0;
    endtask

    initial begin
        // Pulses sampled while in reset must neither start the level nor flag.
        rst   = 1'b0;
        pulse = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_bit("reset level", level, 1'b0);
        check_bit("reset busy", busy, 1'b0);
        check_bit("reset dropped", dropped, 1'b0);

        scen("single", 32'h0000_0400, 32'h0, 32'h0000_7800, 32'h0001_F800, 32'h0);
`ifdef RETRIGGER_EN
        scen("two", 32'h0000_1400, 32'h0, 32'h0001_F800, 32'h0007_F800, 32'h0);
        scen("held", 32'h0000_1C00, 32'h0, 32'h0001_F800, 32'h0007_F800, 32'h0);
`else
        scen("two", 32'h0000_1400, 32'h0, 32'h0000_7800, 32'h0001_F800, 32'h0000_2000);
        scen("held", 32'h0000_1C00, 32'h0, 32'h0000_7800, 32'h0001_F800, 32'h0000_3000);
`endif
        // Pulses in cycles 15 (GAP) and 17 (IDLE after the guard).
        scen("gap", 32'h0002_8400, 32'h0, 32'h003C_7800, 32'h00FD_F800, 32'h0001_0000);
        scen("rst", 32'h0000_2400, 32'h0000_1000, 32'h0003_D800, 32'h000F_D800, 32'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
